// File: rtl/riscv32i.sv
// riscv32i: multi-cycle RV32I core driving external instruction/data BRAM ports.
// Build with STOP_ON_EBREAK_EN defined to make EBREAK end the program.
module riscv32i #(
  parameter int N_param = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_param-1:0] GPIO0_R0_CH1,
  input  logic [N_param-1:0] GPIO0_R0_CH2,
  input  logic [N_param-1:0] GPIO0_R1_CH1,
  input  logic [N_param-1:0] GPIO0_R1_CH2,
  output logic               STOP_sim,
  output logic               data_mem_clkb,
  output logic               data_mem_enb,
  output logic               data_mem_rstb,
  output logic [3:0]         data_mem_web,
  output logic [N_param-1:0] data_mem_addrb,
  output logic [N_param-1:0] data_mem_dinb,
  input  logic [N_param-1:0] data_mem_doutb,
  input  logic               data_mem_rstb_busy,
  output logic               ins_mem_clkb,
  output logic               ins_mem_enb,
  output logic               ins_mem_rstb,
  output logic [3:0]         ins_mem_web,
  output logic [N_param-1:0] ins_mem_addrb,
  output logic [N_param-1:0] ins_mem_dinb,
  input  logic [N_param-1:0] ins_mem_doutb,
  input  logic               ins_mem_rstb_busy
);

  typedef logic [N_param-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, FWAIT, EXEC, MEM, MWAIT, WB
  } state_t;

  state_t state, state_n;

  word_t pc, instr, offset, code;
  word_t alu_q, npc_q, ea_q;
  word_t rf [0:31];
  logic  stop;

  logic run, load;
  assign run  = GPIO0_R0_CH1[0];
  assign load = GPIO0_R0_CH1[1];

  logic unused_ok;
  assign unused_ok = ^{GPIO0_R0_CH1[N_param-1:2],
                       data_mem_rstb_busy, ins_mem_rstb_busy};

  assign data_mem_clkb = clk;
  assign ins_mem_clkb  = clk;
  assign data_mem_rstb = 1'b0;
  assign ins_mem_rstb  = 1'b0;
  assign ins_mem_web   = 4'h0;
  assign ins_mem_dinb  = '0;
  assign STOP_sim      = stop;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_opi, is_op, is_mem, rd_we;
  assign is_lui   = opc == 7'h37;
  assign is_auipc = opc == 7'h17;
  assign is_jal   = opc == 7'h6F;
  assign is_jalr  = opc == 7'h67;
  assign is_br    = opc == 7'h63;
  assign is_ld    = opc == 7'h03;
  assign is_st    = opc == 7'h23;
  assign is_opi   = opc == 7'h13;
  assign is_op    = opc == 7'h33;
  assign is_mem   = is_ld | is_st;
  assign rd_we    = is_lui | is_auipc | is_jal | is_jalr
                  | is_ld | is_opi | is_op;

  word_t i_imm, s_imm, b_imm, u_imm, j_imm;
  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'h000};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  word_t rs1v, rs2v;
  assign rs1v = rf[rs1];
  assign rs2v = rf[rs2];

  function automatic word_t alu(input word_t a, input word_t b,
                                input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? word_t'($signed(a) >>> b[4:0])
                         : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  logic take;
  always_comb begin
    take = 1'b0;
    case (f3)
      3'd0:    take = rs1v == rs2v;
      3'd1:    take = rs1v != rs2v;
      3'd4:    take = $signed(rs1v) < $signed(rs2v);
      3'd5:    take = $signed(rs1v) >= $signed(rs2v);
      3'd6:    take = rs1v < rs2v;
      3'd7:    take = rs1v >= rs2v;
      default: take = 1'b0;
    endcase
  end

  word_t result, npc, ea;
  always_comb begin
    result = '0;
    npc    = pc + 32'd4;
    unique case (1'b1)
      is_lui:   result = u_imm;
      is_auipc: result = pc + u_imm;
      is_jal: begin
        result = pc + 32'd4;
        npc    = pc + j_imm;
      end
      is_jalr: begin
        result = pc + 32'd4;
        npc    = (rs1v + i_imm) & ~32'd1;
      end
      is_br:  if (take) npc = pc + b_imm;
      // SRAI shares imm[30] with ordinary immediates, so gate it by funct3
      is_opi: result = alu(rs1v, i_imm, f3,
                           instr[30] & (f3 == 3'd5));
      is_op:  result = alu(rs1v, rs2v, f3, instr[30]);
      default: result = '0;
    endcase
    ea = rs1v + (is_st ? s_imm : i_imm) - offset;
  end

  word_t lane, ld_val;
  assign lane = data_mem_doutb >> {ea_q[1:0], 3'b000};
  always_comb begin
    case (f3)
      3'd0:    ld_val = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ld_val = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ld_val = {24'h0, lane[7:0]};
      3'd5:    ld_val = {16'h0, lane[15:0]};
      default: ld_val = data_mem_doutb;
    endcase
  end

  logic [3:0] st_mask;
  word_t      st_data;
  always_comb begin
    case (f3[1:0])
      2'd0: begin
        st_mask = 4'b0001 << ea_q[1:0];
        st_data = {4{rs2v[7:0]}};
      end
      2'd1: begin
        st_mask = 4'b0011 << ea_q[1:0];
        st_data = {2{rs2v[15:0]}};
      end
      default: begin
        st_mask = 4'hF;
        st_data = rs2v;
      end
    endcase
  end

  logic sw_hit, ebreak_hit;
  assign sw_hit = (state == MEM) && is_st
               && (f3 == 3'd2) && (rs2v == code);
`ifdef STOP_ON_EBREAK_EN
  assign ebreak_hit = (state == EXEC) && (instr == 32'h0010_0073);
`else
  assign ebreak_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n        = state;
    ins_mem_enb    = 1'b0;
    ins_mem_addrb  = '0;
    data_mem_enb   = 1'b0;
    data_mem_web   = 4'h0;
    data_mem_addrb = '0;
    data_mem_dinb  = '0;
    case (state)
      IDLE:  if (run && !load && !stop) state_n = FETCH;
      FETCH: begin
        ins_mem_enb   = 1'b1;
        ins_mem_addrb = pc;
        state_n       = FWAIT;
      end
      FWAIT: state_n = EXEC;
      EXEC:  state_n = is_mem ? MEM : WB;
      MEM: begin
        data_mem_enb   = 1'b1;
        data_mem_addrb = ea_q;
        if (is_st) begin
          data_mem_web  = st_mask;
          data_mem_dinb = st_data;
        end
        state_n = MWAIT;
      end
      MWAIT: state_n = WB;
      WB:    state_n = (!run || stop) ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= '0;
      instr  <= '0;
      offset <= '0;
      code   <= '0;
      alu_q  <= '0;
      npc_q  <= '0;
      ea_q   <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          pc     <= GPIO0_R1_CH1;
          offset <= GPIO0_R0_CH2;
          code   <= GPIO0_R1_CH2;
        end
        FWAIT: instr <= ins_mem_doutb;
        EXEC: begin
          alu_q <= result;
          npc_q <= npc;
          ea_q  <= ea;
        end
        MWAIT: if (is_ld) alu_q <= ld_val;
        WB:    pc <= npc_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == WB && rd_we && rd != 5'd0) begin
      rf[rd] <= alu_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 stop <= 1'b0;
    else if (sw_hit || ebreak_hit) stop <= 1'b1;
  end

endmodule

// File: tb/tb_riscv32i.sv
// tb_riscv32i: directed program run on riscv32i with BRAM models and
// a scoreboard of expected fetch addresses and store transactions.
module tb_riscv32i;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] gp0c1, gp0c2, gp1c1, gp1c2;
  logic        STOP_sim;
  logic        d_clkb, d_enb, d_rstb;
  logic [3:0]  d_web;
  logic [31:0] d_addrb, d_dinb;
  logic [31:0] d_doutb = '0;
  logic        i_clkb, i_enb, i_rstb;
  logic [3:0]  i_web;
  logic [31:0] i_addrb, i_dinb;
  logic [31:0] i_doutb = '0;

  riscv32i dut (
    .clk(clk), .reset_n(reset_n),
    .GPIO0_R0_CH1(gp0c1), .GPIO0_R0_CH2(gp0c2),
    .GPIO0_R1_CH1(gp1c1), .GPIO0_R1_CH2(gp1c2),
    .STOP_sim(STOP_sim),
    .data_mem_clkb(d_clkb), .data_mem_enb(d_enb),
    .data_mem_rstb(d_rstb), .data_mem_web(d_web),
    .data_mem_addrb(d_addrb), .data_mem_dinb(d_dinb),
    .data_mem_doutb(d_doutb), .data_mem_rstb_busy(1'b0),
    .ins_mem_clkb(i_clkb), .ins_mem_enb(i_enb),
    .ins_mem_rstb(i_rstb), .ins_mem_web(i_web),
    .ins_mem_addrb(i_addrb), .ins_mem_dinb(i_dinb),
    .ins_mem_doutb(i_doutb), .ins_mem_rstb_busy(1'b0)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:255];

  always @(posedge clk) if (i_enb) i_doutb <= imem[i_addrb[11:2]];

  always @(posedge clk) begin
    if (d_enb) begin
      d_doutb <= dmem[d_addrb[9:2]];
      for (int b = 0; b < 4; b++)
        if (d_web[b]) dmem[d_addrb[9:2]][8*b +: 8] <= d_dinb[8*b +: 8];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
  } st_t;

  logic [31:0] fetch_q [$];
  st_t         st_q [$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_on = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] fa;
    st_t         se;
    if (mon_on && i_enb) begin
      tests++;
      assert (fetch_q.size() != 0) else begin
        fails++;
        $error("FAIL fetch_extra got=%h want=none", i_addrb);
      end
      if (fetch_q.size() != 0) begin
        fa = fetch_q.pop_front();
        tests++;
        assert (i_addrb === fa) else begin
          fails++;
          $error("FAIL fetch_addr got=%h want=%h", i_addrb, fa);
        end
      end
    end
    if (mon_on && d_enb && d_web != 4'h0) begin
      tests++;
      assert (st_q.size() != 0) else begin
        fails++;
        $error("FAIL store_extra got=%h/%h/%h want=none",
               d_addrb, d_web, d_dinb);
      end
      if (st_q.size() != 0) begin
        se = st_q.pop_front();
        tests++;
        assert ({d_addrb, d_web, d_dinb} === {se.addr, se.we, se.din})
        else begin
          fails++;
          $error("FAIL store got=%h/%h/%h want=%h/%h/%h",
                 d_addrb, d_web, d_dinb, se.addr, se.we, se.din);
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] im,
    input logic [4:0] r1, input logic [2:0] f, input logic [4:0] d,
    input logic [6:0] op);
    return {im[11:0], r1, f, d, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] im,
    input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f);
    return {im[11:5], r2, r1, f, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] im,
    input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f);
    return {im[12], im[10:5], r2, r1, f, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] im,
    input logic [4:0] d);
    return {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7,
    input logic [4:0] r2, input logic [4:0] r1, input logic [2:0] f,
    input logic [4:0] d);
    return {f7, r2, r1, f, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] im,
    input logic [4:0] d, input logic [6:0] op);
    return {im[19:0], d, op};
  endfunction

  logic [31:0] pa;
  task automatic put(input logic [31:0] w);
    imem[pa[11:2]] = w;
    pa = pa + 32'd4;
  endtask

  task automatic exp_st(input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d);
    st_t s;
    s.addr = a;
    s.we   = w;
    s.din  = d;
    st_q.push_back(s);
  endtask

  int  en_cnt;
  bit  hit;
  logic [31:0] tail [9] = '{32'h45C, 32'h460, 32'h468, 32'h46C,
                            32'h470, 32'h478, 32'h47C, 32'h480, 32'h484};

  initial begin
    reset_n = 1'b0;
    gp0c1 = '0; gp0c2 = '0; gp1c1 = '0; gp1c2 = '0;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    for (int i = 0; i < 256; i++)  dmem[i] = '0;

    pa = 32'h3F8;
    put(enc_i(5, 0, 0, 1, 7'h13));
    put(enc_i(-7, 1, 0, 2, 7'h13));
    put(enc_s(32'h604, 2, 0, 2));
    put(enc_u(32'h12345, 1, 7'h37));
    put(enc_i(32'h678, 1, 0, 1, 7'h13));
    put(enc_s(32'h600, 1, 0, 2));
    put(enc_i(32'h600, 0, 0, 3, 7'h03));
    put(enc_s(32'h608, 3, 0, 2));
    put(enc_i(32'h0AB, 0, 0, 4, 7'h13));
    put(enc_s(32'h603, 4, 0, 0));
    put(enc_i(32'h603, 0, 4, 5, 7'h03));
    put(enc_i(32'h603, 0, 0, 6, 7'h03));
    put(enc_s(32'h60C, 5, 0, 2));
    put(enc_s(32'h610, 6, 0, 2));
    put(enc_r(7'h20, 6, 5, 0, 7));
    put(enc_i(32'h404, 6, 5, 8, 7'h13));
    put(enc_r(7'h00, 6, 5, 3, 9));
    put(enc_r(7'h00, 6, 5, 2, 10));
    put(enc_s(32'h616, 7, 0, 1));
    put(enc_s(32'h618, 8, 0, 2));
    put(enc_i(5, 9, 1, 11, 7'h13));
    put(enc_r(7'h00, 9, 11, 6, 12));
    put(enc_s(32'h61C, 12, 0, 2));
    put(enc_b(8, 10, 9, 1));
    put(enc_s(32'h620, 0, 0, 2));
    put(enc_b(8, 9, 9, 1));
    put(enc_j(8, 13));
    put(enc_s(32'h624, 0, 0, 2));
    put(enc_s(32'h620, 13, 0, 2));
    put(enc_i(32'h479, 0, 0, 14, 7'h13));
    put(enc_i(0, 14, 0, 15, 7'h67));
    put(enc_s(32'h628, 0, 0, 2));
    put(enc_s(32'h624, 15, 0, 2));
    put(enc_u(32'hDEADC, 16, 7'h37));
    put(enc_i(-273, 16, 0, 16, 7'h13));
    put(enc_s(32'h628, 16, 0, 2));
    put(enc_i(1, 0, 0, 17, 7'h13));

    repeat (3) @(negedge clk);
    check("rst_stop", {31'b0, STOP_sim}, 0);
    check("rst_ienb", {31'b0, i_enb}, 0);
    check("rst_denb", {31'b0, d_enb}, 0);
    check("rst_dweb", {28'b0, d_web}, 0);
    check("rst_daddr", d_addrb, 0);
    reset_n = 1'b1;

    gp1c1 = 32'h3F8; gp0c2 = 32'h600; gp1c2 = 32'hDEADBEEF;
    gp0c1 = 32'd2;
    @(negedge clk);
    gp0c1 = 32'd1;
    repeat (8) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_ienb", {31'b0, i_enb}, 0);
    check("midrst_denb", {31'b0, d_enb}, 0);
    check("midrst_stop", {31'b0, STOP_sim}, 0);
    gp0c1 = '0;
    @(negedge clk);
    reset_n = 1'b1;

    gp0c1 = 32'd3;
    en_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_enb) en_cnt++;
    end
    check("load_prio", en_cnt, 0);

    for (logic [31:0] a = 32'h3F8; a <= 32'h454; a += 4)
      fetch_q.push_back(a);
    foreach (tail[i]) fetch_q.push_back(tail[i]);
    exp_st(32'h04, 4'hF, 32'hFFFFFFFE);
    exp_st(32'h00, 4'hF, 32'h12345678);
    exp_st(32'h08, 4'hF, 32'h00000078);
    exp_st(32'h03, 4'h8, 32'hABABABAB);
    exp_st(32'h0C, 4'hF, 32'h000000AB);
    exp_st(32'h10, 4'hF, 32'hFFFFFFAB);
    exp_st(32'h16, 4'hC, 32'h01000100);
    exp_st(32'h18, 4'hF, 32'hFFFFFFFA);
    exp_st(32'h1C, 4'hF, 32'h00000021);
    exp_st(32'h20, 4'hF, 32'h00000464);
    exp_st(32'h24, 4'hF, 32'h00000474);
    exp_st(32'h28, 4'hF, 32'hDEADBEEF);
    mon_on = 1'b1;
    gp0c1 = 32'd1;

    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (d_enb && d_web == 4'hF && d_dinb == 32'hDEADBEEF) hit = 1'b1;
    end
    check("success_store_seen", {31'b0, hit}, 1);
    @(negedge clk);
    check("stop_rise", {31'b0, STOP_sim}, 1);

    repeat (40) @(negedge clk);
    check("stop_hold", {31'b0, STOP_sim}, 1);
    gp0c1 = '0;
    repeat (5) @(negedge clk);
    gp0c1 = 32'd1;
    repeat (20) @(negedge clk);
    check("stop_park", {31'b0, STOP_sim}, 1);
    check("fetch_left", fetch_q.size(), 0);
    check("store_left", st_q.size(), 0);
    check("dmem_w0", dmem[0], 32'hAB345678);
    check("dmem_w5", dmem[5], 32'h01000000);
    check("dmem_w7", dmem[7], 32'h00000021);

    mon_on = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("final_rst_stop", {31'b0, STOP_sim}, 0);
    check("final_rst_ienb", {31'b0, i_enb}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
